// File: rtl/aquarium_mode_sequencer_if.sv
// Sensor sample handshake into aquarium_mode_sequencer: the source drives valid/id/data,
// the sequencer answers with ready.
interface aquarium_mode_sequencer_if;
    logic       sample_valid;
    logic [1:0] sample_id;
    logic [7:0] sample_data;
    logic       sample_ready;

    modport master (
        output sample_valid,
        output sample_id,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_id,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/aquarium_mode_sequencer.sv
// Aquarium display-mode sequencer: loads range-checked sensor samples and steps the display
// select code. Define AQ_ERR_AUTOCLR_EN to leave ERROR automatically after 4*DWELL_CYCLES.
module aquarium_mode_sequencer #(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter logic [7:0]  CLEAN_MIN    = 8'd10,
    parameter logic [7:0]  TEMP_MAX     = 8'd40,
    parameter logic [7:0]  FOOD_MIN     = 8'd5,
    parameter logic [7:0]  SALT_MAX     = 8'd100
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            err_clear,
    aquarium_mode_sequencer_if.slave        smp,
    output logic                            ld_cleanliness,
    output logic                            ld_temperature,
    output logic                            ld_food_storage,
    output logic                            ld_saltiness,
    output logic [7:0]                      d_out,
    output logic [4:0]                      select,
    output logic [7:0]                      count,
    output logic                            error
);

    // State encoding doubles as the registered display select code.
    typedef enum logic [4:0] {
        StIdle      = 5'b00000,
        StCount     = 5'b00001,
        StShowClean = 5'b00010,
        StShowTemp  = 5'b00100,
        StShowFood  = 5'b01000,
        StShowSalt  = 5'b10000,
        StError     = 5'b11111
    } state_e;

    localparam logic [9:0] DwellLast = 10'(DWELL_CYCLES - 1);
`ifdef AQ_ERR_AUTOCLR_EN
    localparam logic [9:0] ErrLast = 10'(4 * DWELL_CYCLES - 1);
`endif

    state_e     state_q, state_d;
    logic [9:0] dwell_q, dwell_d;
    logic [7:0] count_q, count_d;
    logic [7:0] d_out_q, d_out_d;
    logic [3:0] ld_q, ld_d;
    logic       ready_q, ready_d;
    logic       accept, range_fail, dwell_done;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            dwell_q <= '0;
            count_q <= '0;
            d_out_q <= '0;
            ld_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            count_q <= count_d;
            d_out_q <= d_out_d;
            ld_q    <= ld_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        count_d    = count_q;
        d_out_d    = d_out_q;
        ld_d       = 4'b0000;
        range_fail = 1'b0;
        accept     = smp.sample_valid && ready_q;
        dwell_done = (dwell_q == DwellLast);

        unique case (smp.sample_id)
            2'd0:    range_fail = smp.sample_data < CLEAN_MIN;
            2'd1:    range_fail = smp.sample_data > TEMP_MAX;
            2'd2:    range_fail = smp.sample_data < FOOD_MIN;
            default: range_fail = smp.sample_data > SALT_MAX;
        endcase

        unique case (state_q)
            StIdle:      if (start) state_d = StCount;
            StCount:     if (dwell_done) state_d = StShowClean;
            StShowClean: if (dwell_done) state_d = StShowTemp;
            StShowTemp:  if (dwell_done) state_d = StShowFood;
            StShowFood:  if (dwell_done) state_d = StShowSalt;
            StShowSalt:  if (dwell_done) state_d = StCount;
            StError: begin
                if (err_clear) state_d = StIdle;
`ifdef AQ_ERR_AUTOCLR_EN
                else if (dwell_q == ErrLast) state_d = StIdle;
`endif
            end
            default:     state_d = StIdle;
        endcase

        // A bad sample lands in ERROR on the same edge that raises its strobe.
        if (accept && range_fail) state_d = StError;

        if (accept) begin
            ld_d    = 4'b0001 << smp.sample_id;
            d_out_d = smp.sample_data;
        end

        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (state_q != StIdle && state_q != StError) begin
            dwell_d = dwell_q + 10'd1;
        end
`ifdef AQ_ERR_AUTOCLR_EN
        else if (state_q == StError) begin
            dwell_d = dwell_q + 10'd1;
        end
`endif

        if (state_d == StCount && state_q != StCount) count_d = count_q + 8'd1;

        ready_d = (state_d != StError) && !accept;
    end

    assign smp.sample_ready  = ready_q;
    assign ld_cleanliness    = ld_q[0];
    assign ld_temperature    = ld_q[1];
    assign ld_food_storage   = ld_q[2];
    assign ld_saltiness      = ld_q[3];
    assign d_out             = d_out_q;
    assign select            = state_q;
    assign count             = count_q;
    assign error             = (state_q == StError);

endmodule
